// File: rtl/mole_round_scheduler.sv
// Whack-a-mole appearance sequencer: fetches a random hole, shows it for a timed
// window, resolves hit/miss, then holds a blank gap. Each hit shortens the window.
//
// state | meaning
// IDLE  | game not running, outputs quiet, counters held for readout
// REQ   | rand_req high, waiting for a legal position from the generator
// SHOW  | one mole visible, window down-counter running
// GAP   | blank interval before the next request
module mole_round_scheduler #(
  parameter int TICK_DIV     = 50000,
  parameter int UP_TIME_INIT = 1000,
  parameter int UP_TIME_MIN  = 200,
  parameter int UP_TIME_STEP = 50,
  parameter int GAP_TIME     = 250
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic        rand_req,
  input  logic        rand_valid,
  input  logic [2:0]  rand_mole,
  input  logic        whack_valid,
  input  logic [2:0]  whack_idx,
  output logic [4:0]  moles_shown,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic [7:0]  round_count,
  output logic [15:0] up_time_cur
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [15:0] UP_INIT    = 16'(UP_TIME_INIT);
  localparam logic [15:0] UP_MIN     = 16'(UP_TIME_MIN);
  localparam logic [15:0] UP_STEP    = 16'(UP_TIME_STEP);
  localparam logic [15:0] GAP_TICKS  = 16'(GAP_TIME);
  localparam logic [16:0] STEP_FLOOR = 17'(UP_TIME_MIN + UP_TIME_STEP);

  typedef enum logic [1:0] {IDLE, REQ, SHOW, GAP} stateT;

  stateT            state, nextState;
  logic [2:0]       idx, nextIdx;
  logic [PRE_W-1:0] preCnt, nextPre;
  logic [15:0]      timerCnt, nextTimer;
  logic             nextRandReq, nextHit, nextMiss;
  logic [4:0]       nextMoles;
  logic [7:0]       nextRound, roundInc;
  logic [15:0]      nextUp, upStepped;
  logic             tick, timerLast;

  assign tick      = (preCnt == PRE_LAST);
  assign timerLast = (timerCnt <= 16'd1);
  assign roundInc  = (round_count == 8'hFF) ? round_count : round_count + 8'd1;
  // Compare in 17 bits so the subtraction below can never wrap.
  assign upStepped = ({1'b0, up_time_cur} >= STEP_FLOOR) ? up_time_cur - UP_STEP : UP_MIN;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= 3'd0;
      preCnt      <= '0;
      timerCnt    <= 16'd0;
      rand_req    <= 1'b0;
      moles_shown <= 5'd0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      round_count <= 8'd0;
      up_time_cur <= UP_INIT;
    end else begin
      state       <= nextState;
      idx         <= nextIdx;
      preCnt      <= nextPre;
      timerCnt    <= nextTimer;
      rand_req    <= nextRandReq;
      moles_shown <= nextMoles;
      hit_pulse   <= nextHit;
      miss_pulse  <= nextMiss;
      round_count <= nextRound;
      up_time_cur <= nextUp;
    end
  end

  always_comb begin
    nextState   = state;
    nextIdx     = idx;
    nextPre     = tick ? '0 : preCnt + PRE_ONE;
    nextTimer   = timerCnt;
    nextRandReq = 1'b0;
    nextMoles   = 5'd0;
    nextHit     = 1'b0;
    nextMiss    = 1'b0;
    nextRound   = round_count;
    nextUp      = up_time_cur;

    case (state)
      IDLE: begin
        nextPre = '0;
        if (enable) begin
          nextState   = REQ;
          nextRandReq = 1'b1;
          nextRound   = 8'd0;
          nextUp      = UP_INIT;
        end
      end
      REQ: begin
        nextPre     = '0;
        nextRandReq = 1'b1;
        if (rand_valid && (rand_mole <= 3'd4)) begin
          nextState   = SHOW;
          nextIdx     = rand_mole;
          nextRandReq = 1'b0;
          nextMoles   = 5'b00001 << rand_mole;
          nextTimer   = up_time_cur;
        end
      end
      SHOW: begin
        nextMoles = moles_shown;
        // A hit on the expiry cycle takes priority over the miss.
        if (whack_valid && (whack_idx == idx)) begin
          nextState = GAP;
          nextMoles = 5'd0;
          nextHit   = 1'b1;
          nextPre   = '0;
          nextTimer = GAP_TICKS;
          nextRound = roundInc;
          nextUp    = upStepped;
        end else if (tick) begin
          if (timerLast) begin
            nextState = GAP;
            nextMoles = 5'd0;
            nextMiss  = 1'b1;
            nextPre   = '0;
            nextTimer = GAP_TICKS;
            nextRound = roundInc;
          end else begin
            nextTimer = timerCnt - 16'd1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (timerLast) begin
            nextState   = REQ;
            nextRandReq = 1'b1;
            nextPre     = '0;
          end else begin
            nextTimer = timerCnt - 16'd1;
          end
        end
      end
      default: nextState = IDLE;
    endcase

    // Leaving INGAME drops any pending outcome but keeps score and window for readout.
    if (!enable) begin
      nextState   = IDLE;
      nextRandReq = 1'b0;
      nextMoles   = 5'd0;
      nextHit     = 1'b0;
      nextMiss    = 1'b0;
      nextPre     = '0;
      nextRound   = round_count;
      nextUp      = up_time_cur;
    end
  end

endmodule
